// File: rtl/dense_seq_mac.sv
// Fully-connected layer sequencer: one registered MAC walks out_len neurons of in_len inputs plus
// a bias, and writes one rounded, saturated, optionally ReLU'd word per neuron to pixel memory.
module dense_seq_mac #(
  parameter int DATA_W  = 11,
  parameter int FRAC    = 10,
  parameter int ACC_W   = 32,
  parameter int IN_W    = 10,
  parameter int OUT_W   = 7,
  parameter int PIX_AW  = 13,
  parameter int WEI_AW  = 13,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_W-1:0]   in_len,
  input  logic [OUT_W-1:0]  out_len,
  input  logic              relu_en,
  input  logic [PIX_AW-1:0] pix_base,
  input  logic [WEI_AW-1:0] wei_base,
  input  logic [PIX_AW-1:0] dst_base,
  output logic              pix_re,
  output logic [PIX_AW-1:0] pix_addr,
  input  logic [DATA_W-1:0] pix_q,
  output logic              wei_re,
  output logic [WEI_AW-1:0] wei_addr,
  input  logic [DATA_W-1:0] wei_q,
  output logic              wr_en,
  output logic [PIX_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              ovf
);
  // Handshake: start is a one-cycle request honoured only in S_IDLE; done is a one-cycle pulse
  // one cycle after the final write, and busy is high from the cycle after start until done.
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;

  localparam int DCW = $clog2(MEM_LAT + 3);
  localparam int PW  = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = 2 ** (DATA_W - 1) - 1;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(2 ** (DATA_W - 1));

  state_t state, state_nxt;
  logic start_ok, last_k, last_n, drain_end, acc_clr;
  logic [IN_W-1:0]   in_len_l, k;
  logic [OUT_W-1:0]  out_len_l, n;
  logic              relu_l;
  logic [PIX_AW-1:0] pix_base_l, dst_base_l;
  logic [WEI_AW-1:0] wei_ptr;
  logic [DCW-1:0]    dcnt;
  logic [MEM_LAT-1:0] vld_sr, bias_sr;
  logic signed [DATA_W-1:0] pix_s, wei_s;
  logic signed [PW-1:0]     mul, bias_term, prod;
  logic                     prod_vld;
  logic signed [ACC_W-1:0]  acc, prod_ext, rnd_sum, shifted;
  logic [DATA_W-1:0]        post_val;
  logic                     post_sat;

  assign start_ok  = (state == S_IDLE) && start;
  assign last_k    = (k == in_len_l);
  assign last_n    = (n == out_len_l - OUT_W'(1));
  assign drain_end = (dcnt == DCW'(MEM_LAT + 1));
  assign acc_clr   = (state_nxt == S_FETCH) && (state != S_FETCH);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (out_len == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (last_k) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_end) state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_n ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The k == in_len slot fetches only the bias; no pixel read is issued for it.
  always_comb begin
    pix_re   = 1'b0;
    wei_re   = 1'b0;
    pix_addr = '0;
    wei_addr = '0;
    busy     = (state != S_IDLE);
    if (state == S_FETCH) begin
      wei_re   = 1'b1;
      wei_addr = wei_ptr;
      if (!last_k) begin
        pix_re   = 1'b1;
        pix_addr = pix_base_l + PIX_AW'(k);
      end
    end
  end

  assign pix_s     = pix_q;
  assign wei_s     = wei_q;
  assign mul       = pix_s * wei_s;
  assign bias_term = {{(PW - DATA_W - FRAC){wei_s[DATA_W-1]}}, wei_s, {FRAC{1'b0}}};
  assign prod_ext  = {{(ACC_W - PW){prod[PW-1]}}, prod};
  assign rnd_sum   = acc + (ACC_W'(1) << (FRAC - 1));
  assign shifted   = rnd_sum >>> FRAC;

  // Round half up, saturate (flagging ovf), then ReLU.
  always_comb begin
    post_sat = 1'b0;
    post_val = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX) begin
      post_sat = 1'b1;
      post_val = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      post_sat = 1'b1;
      post_val = {1'b1, {(DATA_W-1){1'b0}}};
    end
    if (relu_l && post_val[DATA_W-1]) post_val = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_len_l   <= '0;
      out_len_l  <= '0;
      relu_l     <= 1'b0;
      pix_base_l <= '0;
      dst_base_l <= '0;
      wei_ptr    <= '0;
      k          <= '0;
      n          <= '0;
      dcnt       <= '0;
      vld_sr     <= '0;
      bias_sr    <= '0;
      prod       <= '0;
      prod_vld   <= 1'b0;
      acc        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      vld_sr[0]  <= wei_re;
      bias_sr[0] <= wei_re && !pix_re;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        bias_sr[i] <= bias_sr[i-1];
      end
      prod_vld <= vld_sr[MEM_LAT-1];
      prod     <= bias_sr[MEM_LAT-1] ? bias_term : mul;
      if (acc_clr)       acc <= '0;
      else if (prod_vld) acc <= acc + prod_ext;

      wr_en   <= (state == S_WRITE);
      wr_addr <= (state == S_WRITE) ? dst_base_l + PIX_AW'(n) : '0;
      wr_data <= (state == S_WRITE) ? post_val : '0;
      done    <= (state == S_DONE);

      if (start_ok) begin
        in_len_l   <= in_len;
        out_len_l  <= out_len;
        relu_l     <= relu_en;
        pix_base_l <= pix_base;
        dst_base_l <= dst_base;
        wei_ptr    <= wei_base;
        k          <= '0;
        n          <= '0;
        ovf        <= 1'b0;
      end
      // Weight blocks are contiguous per neuron, so the pointer just keeps running.
      if (state == S_FETCH) begin
        wei_ptr <= wei_ptr + WEI_AW'(1);
        k       <= last_k ? '0 : k + IN_W'(1);
      end
      dcnt <= (state == S_DRAIN && !drain_end) ? dcnt + DCW'(1) : '0;
      if (state == S_WRITE) begin
        n   <= n + OUT_W'(1);
        ovf <= ovf | post_sat;
      end
    end
  end
endmodule
